// File: rtl/ifetch_queue.sv
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction prefetch queue; fetches words over req/ack and
//               presents IR + PC to decode over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST_F,
    input  logic        flush,
    input  logic [15:0] flush_addr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir_data,
    output logic [15:0] ir_pc,
    input  logic        ir_ready
);

    localparam int unsigned             c_ptr_w = $clog2(DEPTH);
    localparam int unsigned             c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]      c_full  = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   w_count_next;
    logic [15:0]          r_fetch_pc;
    logic [15:0]          w_fetch_pc_next;
    logic [15:0]          r_mem_addr;
    logic [31:0]          r_buf_data [DEPTH];
    logic [15:0]          r_buf_pc   [DEPTH];
    logic                 w_push;
    logic                 w_pop;

    // A flush kills both the in-flight response and any decode consumption.
    assign w_push = (r_state == REQ) && mem_ack && !flush;
    assign w_pop  = ir_ready && (r_count != '0) && !flush;

    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_cnt_w'(1);
        end
    end

    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (flush) begin
            w_fetch_pc_next = flush_addr;
        end else if (w_push) begin
            w_fetch_pc_next = r_fetch_pc + 16'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_count_next < c_full) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    // The handshake cannot be withdrawn, so an unacked request
                    // must be drained before fetching from the new address.
                    w_state_next = mem_ack ? REQ : DISCARD;
                end else if (!(w_count_next < c_full)) begin
                    w_state_next = IDLE;
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    w_state_next = REQ;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_fetch_pc <= w_fetch_pc_next;
            // mem_addr stays on the abandoned address until its ack arrives.
            if (w_state_next != DISCARD) begin
                r_mem_addr <= w_fetch_pc_next;
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_buf_data[r_wr_ptr] <= mem_rdata;
            r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign mem_req  = (r_state != IDLE);
    assign mem_addr = r_mem_addr;
    assign ir_valid = (r_count != '0);
    assign ir_data  = r_buf_data[r_rd_ptr];
    assign ir_pc    = r_buf_pc[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Directed self-checking bench for ifetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_queue;

    logic        CLK        = 1'b0;
    logic        RST_F      = 1'b0;
    logic        flush      = 1'b0;
    logic [15:0] flush_addr = 16'h0000;
    logic        mem_ack    = 1'b0;
    logic        ir_ready   = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        ir_valid;
    logic [31:0] ir_data;
    logic [15:0] ir_pc;

    int n_vec = 0;
    int n_err = 0;

    ifetch_queue #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .CLK        (CLK),
        .RST_F      (RST_F),
        .flush      (flush),
        .flush_addr (flush_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir_valid   (ir_valid),
        .ir_data    (ir_data),
        .ir_pc      (ir_pc),
        .ir_ready   (ir_ready)
    );

    always #5 CLK = ~CLK;

    // Instruction memory contents: each word tags its own address.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic reset_dut();
        RST_F    = 1'b0;
        flush    = 1'b0;
        mem_ack  = 1'b0;
        ir_ready = 1'b0;
        repeat (2) step();
    endtask

    logic [15:0] wrap_exp [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_dut();
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir_data",  ir_data,       32'd0);
        chk("rst_ir_pc",    32'(ir_pc),    32'd0);

        // Streaming fetch, ack every cycle, decode always ready
        mem_ack  = 1'b1;
        ir_ready = 1'b1;
        RST_F    = 1'b1;
        step();
        chk("t1_req",    32'(mem_req),  32'd1);
        chk("t1_addr0",  32'(mem_addr), 32'd0);
        chk("t1_valid0", 32'(ir_valid), 32'd0);
        step();
        chk("t1_valid1", 32'(ir_valid), 32'd1);
        chk("t1_pc0",    32'(ir_pc),    32'd0);
        chk("t1_data0",  ir_data,       mem_word(16'h0000));
        chk("t1_addr1",  32'(mem_addr), 32'd1);
        for (int k = 2; k < 5; k++) begin
            step();
            chk("t1_addr", 32'(mem_addr), 32'(k));
            chk("t1_pc",   32'(ir_pc),    32'(k - 1));
            chk("t1_data", ir_data,       mem_word(16'(k - 1)));
        end

        // Fill to full with decode stalled
        reset_dut();
        mem_ack  = 1'b1;
        ir_ready = 1'b0;
        RST_F    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_fill_req",  32'(mem_req),  32'd1);
            chk("t2_fill_addr", 32'(mem_addr), 32'(k));
        end
        step();
        chk("t2_full_req", 32'(mem_req), 32'd0);
        chk("t2_full_pc",  32'(ir_pc),   32'd0);
        step();
        chk("t2_hold_req",  32'(mem_req), 32'd0);
        chk("t2_hold_pc",   32'(ir_pc),   32'd0);
        chk("t2_hold_data", ir_data,      mem_word(16'h0000));
        ir_ready = 1'b1;
        step();
        chk("t2_refill_req",  32'(mem_req),  32'd1);
        chk("t2_refill_addr", 32'(mem_addr), 32'd4);
        chk("t2_pop_pc",      32'(ir_pc),    32'd1);
        ir_ready = 1'b0;
        step();
        chk("t2_refull_req", 32'(mem_req), 32'd0);
        chk("t2_refull_pc",  32'(ir_pc),   32'd1);
        ir_ready = 1'b1;
        mem_ack  = 1'b0;
        for (int k = 2; k < 5; k++) begin
            step();
            chk("t2_drain_pc", 32'(ir_pc), 32'(k));
        end
        step();
        chk("t2_empty", 32'(ir_valid), 32'd0);

        // Flush while request to address 5 is pending
        chk("t3_pend_req",  32'(mem_req),  32'd1);
        chk("t3_pend_addr", 32'(mem_addr), 32'd5);
        flush      = 1'b1;
        flush_addr = 16'h0040;
        step();
        flush = 1'b0;
        chk("t3_disc_req",   32'(mem_req),  32'd1);
        chk("t3_disc_addr",  32'(mem_addr), 32'd5);
        chk("t3_disc_valid", 32'(ir_valid), 32'd0);
        repeat (2) begin
            step();
            chk("t3_disc_hold", 32'(mem_addr), 32'd5);
        end
        mem_ack = 1'b1;
        step();
        chk("t3_new_addr",   32'(mem_addr), 32'h40);
        chk("t3_drop_valid", 32'(ir_valid), 32'd0);
        step();
        chk("t3_first_valid", 32'(ir_valid), 32'd1);
        chk("t3_first_pc",    32'(ir_pc),    32'h40);
        chk("t3_first_data",  ir_data,       mem_word(16'h0040));

        // Flush coinciding with mem_ack and ir_ready
        flush      = 1'b1;
        flush_addr = 16'h0080;
        step();
        flush = 1'b0;
        chk("t4_valid", 32'(ir_valid), 32'd0);
        chk("t4_req",   32'(mem_req),  32'd1);
        chk("t4_addr",  32'(mem_addr), 32'h80);
        step();
        chk("t4_next_valid", 32'(ir_valid), 32'd1);
        chk("t4_next_pc",    32'(ir_pc),    32'h80);

        // Fetch PC wraps at 16 bits
        flush      = 1'b1;
        flush_addr = 16'hFFFE;
        step();
        flush = 1'b0;
        chk("t5_addr",  32'(mem_addr), 32'hFFFE);
        chk("t5_valid", 32'(ir_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_wrap_pc", 32'(ir_pc), 32'(wrap_exp[i]));
        end

        // Asynchronous reset with two entries queued and a request pending
        ir_ready = 1'b0;
        step();
        chk("t6_pre_valid", 32'(ir_valid), 32'd1);
        chk("t6_pre_pc",    32'(ir_pc),    32'h0001);
        chk("t6_pre_addr",  32'(mem_addr), 32'h0003);
        mem_ack = 1'b0;
        #2;
        RST_F = 1'b0;
        #1;
        chk("t6_rst_req",   32'(mem_req),  32'd0);
        chk("t6_rst_addr",  32'(mem_addr), 32'd0);
        chk("t6_rst_valid", 32'(ir_valid), 32'd0);
        chk("t6_rst_data",  ir_data,       32'd0);
        chk("t6_rst_pc",    32'(ir_pc),    32'd0);
        mem_ack = 1'b1;
        repeat (2) step();
        chk("t6_in_rst_valid", 32'(ir_valid), 32'd0);
        ir_ready = 1'b1;
        RST_F    = 1'b1;
        step();
        chk("t6_restart_req",   32'(mem_req),  32'd1);
        chk("t6_restart_addr",  32'(mem_addr), 32'd0);
        chk("t6_restart_valid", 32'(ir_valid), 32'd0);
        step();
        chk("t6_restart_pc",   32'(ir_pc), 32'd0);
        chk("t6_restart_data", ir_data,    mem_word(16'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
